// File: rtl/ins_cache.sv
// ins_cache: direct-mapped, read-only instruction cache with 4-word lines.
// A hit returns the word combinationally. A miss refills the line one word
// at a time through a req/done handshake with the memory controller.
module ins_cache #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] addr,
  output logic        hit,
  output logic [31:0] ins,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 28 - INDEX_BITS;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                          state;
  logic [1:0]                      cnt;
  logic [LINES-1:0]                valid;
  logic [LINES-1:0][TAG_W-1:0]     tag_arr;
  logic [LINES-1:0][3:0][31:0]     data_arr;
  // Line address (addr[31:4]) of the line being filled. The fill is indexed
  // and tagged from this, so a fetch redirect mid-fill cannot corrupt it.
  logic [27:0]                     fill_base;

  logic [1:0]            offset;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_W-1:0]      tag;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_W-1:0]      fill_tag;
  logic                  fill_write;
  logic                  unused_ok;

  assign offset     = addr[3:2];
  assign index      = addr[INDEX_BITS+3:4];
  assign tag        = addr[31:INDEX_BITS+4];
  assign fill_index = fill_base[INDEX_BITS-1:0];
  assign fill_tag   = fill_base[27:INDEX_BITS];
  assign fill_write = (state == FILL) && rdy && mem_done && !rst;
  // PC is word-aligned, so the byte offset bits carry no information.
  assign unused_ok  = &{1'b0, addr[1:0]};

  // Lookup: no hit-under-miss, so hit is suppressed for the whole fill.
  always_comb begin
    hit = (state == IDLE) && valid[index] && (tag_arr[index] == tag);
    ins = hit ? data_arr[index][offset] : 32'b0;
  end

  // Control FSM: miss detection, word sequencing and valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      valid     <= '0;
      cnt       <= 2'd0;
      mem_req   <= 1'b0;
      mem_addr  <= 32'b0;
      fill_base <= 28'b0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          if (!hit) begin
            fill_base    <= addr[31:4];
            valid[index] <= 1'b0;
            cnt          <= 2'd0;
            mem_req      <= 1'b1;
            mem_addr     <= {addr[31:4], 4'b0};
            state        <= FILL;
          end
        end
        FILL: begin
          if (mem_done) begin
            if (cnt == 2'd3) begin
              valid[fill_index] <= 1'b1;
              mem_req           <= 1'b0;
              state             <= IDLE;
            end else begin
              cnt      <= cnt + 2'd1;
              mem_addr <= mem_addr + 32'd4;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data and tag storage: written only by the fill, never reset. The tag is
  // installed with the last word, together with the valid bit.
  always_ff @(posedge clk) begin
    if (fill_write) begin
      data_arr[fill_index][cnt] <= mem_data;
      if (cnt == 2'd3) tag_arr[fill_index] <= fill_tag;
    end
  end
endmodule

// File: tb/tb_ins_cache.sv
// Directed bench for ins_cache: a memory responder with fixed latency, an
// edge monitor recording accepted word addresses, and one task per scenario.
module tb_ins_cache;
  logic        clk = 1'b0;
  logic        rst, rdy;
  logic [31:0] addr;
  logic        hit;
  logic [31:0] ins;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;
  logic        done_q;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_done = -1;
  logic [31:0] acc_q[$];

  localparam int LAT = 2;

  ins_cache #(.INDEX_BITS(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .addr(addr), .hit(hit), .ins(ins),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done),
    .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  // Controller is rdy-gated: a pending word is held while rdy is low.
  assign mem_done = done_q && rdy;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'h10) return ({30'b0, a[3:2]} + 32'd1) * 32'h11111111;
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  // Memory responder: LAT cycles after a request is seen, present the word.
  initial begin
    bit fired;
    int wcnt;
    done_q = 1'b0;
    mem_data = 32'b0;
    wcnt = 0;
    forever begin
      @(posedge clk);
      fired = mem_done;
      #2;
      if (rst || !mem_req || fired) begin
        done_q = 1'b0;
        wcnt = 0;
      end else if (!done_q) begin
        if (wcnt == LAT - 1) begin
          done_q = 1'b1;
          mem_data = mem_word(mem_addr);
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Edge monitor: cycle count and the address of every accepted word.
  always @(posedge clk) begin
    cyc++;
    if (mem_done && rdy && !rst) begin
      acc_q.push_back(mem_addr);
      last_done = cyc;
    end
  end

  task automatic wait_hit(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (hit) begin ok = 1'b1; return; end
    end
  endtask

  task automatic wait_q(input int sz, input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (acc_q.size() >= sz) begin ok = 1'b1; return; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; rdy = 1'b0; addr = 32'h0;
    repeat (2) @(negedge clk);
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%b want=0", hit); end
    checks++; if (ins !== 32'b0) begin failures++; $display("FAIL reset_ins got=%h want=0", ins); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b want=0", mem_req); end
    checks++; if (mem_addr !== 32'b0) begin failures++; $display("FAIL reset_maddr got=%h want=0", mem_addr); end
    rst = 1'b0;
  endtask

  task automatic test_cold_miss;
    bit ok;
    acc_q.delete();
    addr = 32'h0; rdy = 1'b1;
    #1;
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL cold_first_cycle_hit got=%b want=0", hit); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin failures++; $display("FAIL cold_req got=%b/%h want=1/00000000", mem_req, mem_addr); end
    wait_hit(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL cold_timeout got=no_hit want=hit"); end
    checks++; if (cyc != last_done) begin failures++; $display("FAIL cold_hit_latency got=%0d want=%0d", cyc, last_done); end
    checks++; if (ins !== 32'h11111111) begin failures++; $display("FAIL cold_ins got=%h want=11111111", ins); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL cold_req_drop got=%b want=0", mem_req); end
    checks++;
    if (acc_q.size() != 4 || acc_q[0] !== 32'h0 || acc_q[1] !== 32'h4 || acc_q[2] !== 32'h8 || acc_q[3] !== 32'hC) begin
      failures++; $display("FAIL cold_addr_seq got=%p want=0,4,8,c", acc_q);
    end
    addr = 32'h8; #1;
    checks++; if (hit !== 1'b1 || ins !== 32'h33333333) begin failures++; $display("FAIL cold_word2 got=%b/%h want=1/33333333", hit, ins); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL cold_no_req got=%b want=0", mem_req); end
  endtask

  task automatic test_conflict;
    bit ok;
    acc_q.delete();
    addr = 32'h100;
    wait_hit(100, ok);
    checks++; if (!ok || ins !== mem_word(32'h100)) begin failures++; $display("FAIL conflict_fill got=%b/%h want=1/%h", hit, ins, mem_word(32'h100)); end
    checks++;
    if (acc_q.size() != 4 || acc_q[0] !== 32'h100 || acc_q[3] !== 32'h10C) begin
      failures++; $display("FAIL conflict_seq got=%p want=100..10c", acc_q);
    end
    addr = 32'h0; #1;
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL conflict_evicted got=%b want=0", hit); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin failures++; $display("FAIL conflict_refill got=%b/%h want=1/00000000", mem_req, mem_addr); end
    wait_hit(100, ok);
    checks++; if (!ok || ins !== 32'h11111111) begin failures++; $display("FAIL conflict_rehit got=%b/%h want=1/11111111", hit, ins); end
  endtask

  task automatic test_no_hit_under_miss;
    bit ok;
    int bad;
    addr = 32'h10;
    wait_hit(100, ok);
    checks++; if (!ok || ins !== mem_word(32'h10)) begin failures++; $display("FAIL nhum_line10 got=%b/%h want=1/%h", hit, ins, mem_word(32'h10)); end
    acc_q.delete();
    addr = 32'h40;
    @(negedge clk);
    addr = 32'h14;
    bad = 0;
    for (int i = 0; i < 100 && mem_req; i++) begin
      #1; if (hit !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL nhum_hit_in_fill got=%0d want=0", bad); end
    checks++; if (hit !== 1'b1 || ins !== mem_word(32'h14)) begin failures++; $display("FAIL nhum_after got=%b/%h want=1/%h", hit, ins, mem_word(32'h14)); end
    checks++;
    if (acc_q.size() != 4 || acc_q[0] !== 32'h40 || acc_q[3] !== 32'h4C) begin
      failures++; $display("FAIL nhum_seq got=%p want=40..4c", acc_q);
    end
    addr = 32'h48; #1;
    checks++; if (hit !== 1'b1 || ins !== mem_word(32'h48)) begin failures++; $display("FAIL nhum_installed got=%b/%h want=1/%h", hit, ins, mem_word(32'h48)); end
    @(negedge clk);
  endtask

  task automatic test_rdy_stall;
    bit ok;
    int bad;
    acc_q.delete();
    addr = 32'h80;
    wait_q(2, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_reach_cnt2 got=%0d want=2", acc_q.size()); end
    rdy = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (mem_addr !== 32'h88 || mem_req !== 1'b1 || hit !== 1'b0 || acc_q.size() != 2) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL stall_hold got=%0d_bad_cycles want=0 maddr=%h", bad, mem_addr); end
    rdy = 1'b1;
    wait_hit(100, ok);
    checks++; if (!ok || ins !== mem_word(32'h80)) begin failures++; $display("FAIL stall_finish got=%b/%h want=1/%h", hit, ins, mem_word(32'h80)); end
    checks++;
    if (acc_q.size() != 4 || acc_q[2] !== 32'h88 || acc_q[3] !== 32'h8C) begin
      failures++; $display("FAIL stall_seq got=%p want=80..8c", acc_q);
    end
  endtask

  task automatic test_reset_midfill;
    bit ok;
    acc_q.delete();
    addr = 32'hC0;
    wait_q(1, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rstmid_reach_cnt1 got=%0d want=1", acc_q.size()); end
    rst = 1'b1; rdy = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin failures++; $display("FAIL rstmid_outputs got=%b/%h want=0/00000000", mem_req, mem_addr); end
    rst = 1'b0;
    addr = 32'h10; #1;
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL rstmid_old_line got=%b want=0", hit); end
    @(negedge clk);
    checks++; if (hit !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL rstmid_idle got=%b/%b want=0/0", hit, mem_req); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int bad;
    acc_q.delete();
    rdy = 1'b1; addr = 32'h0;
    wait_hit(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_first got=no_hit want=hit"); end
    addr = 32'h10;
    wait_hit(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_second got=no_hit want=hit"); end
    checks++; if (acc_q.size() != 8) begin failures++; $display("FAIL b2b_words got=%0d want=8", acc_q.size()); end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      addr = 32'(i * 4); #1;
      if (hit !== 1'b1 || ins !== mem_word(32'(i * 4))) begin
        bad++; $display("FAIL b2b_word addr=%h got=%b/%h want=1/%h", addr, hit, ins, mem_word(32'(i * 4)));
      end
    end
    checks++; if (bad != 0) failures++;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL b2b_no_req got=%b want=0", mem_req); end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b0; addr = 32'h0;
    @(negedge clk);
    test_reset;
    test_cold_miss;
    test_conflict;
    test_no_hit_under_miss;
    test_rdy_stall;
    test_reset_midfill;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
